// File: rtl/activation_stage_if.sv
// Beat bus between the pool stage and the activation stage.
// The master drives the input beat; the slave returns the activated beat.
interface activation_stage_if #(
    parameter int MAT_MUL_SIZE = 8,
    parameter int DWIDTH       = 8,
    parameter int MASK_WIDTH   = MAT_MUL_SIZE
);
    logic                           in_data_available;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data;
    logic [MASK_WIDTH-1:0]          validity_mask;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data;
    logic                           out_data_available;

    modport master (
        output in_data_available, inp_data, validity_mask,
        input  out_data, out_data_available
    );

    modport slave (
        input  in_data_available, inp_data, validity_mask,
        output out_data, out_data_available
    );
endinterface

// File: rtl/activation_stage.sv
// Per-lane ReLU / piecewise-linear tanh on Q4.4 beats, 2-cycle fixed latency.
// One beat per cycle, no backpressure; bypass passes the beat through combinationally.
module activation_stage #(
    parameter int MAT_MUL_SIZE = 8,
    parameter int DWIDTH       = 8,
    parameter int MASK_WIDTH   = MAT_MUL_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_activation,
    input  logic              activation_type,
    activation_stage_if.slave bus,
    output logic              done_activation
);
    localparam int IW = DWIDTH + 2;
    localparam int CW = $clog2(MAT_MUL_SIZE + 1);
    localparam logic [IW-1:0] MAG_MAX = IW'((1 << (DWIDTH - 1)) - 1);
    localparam logic [CW-1:0] BEATS   = CW'(MAT_MUL_SIZE);

    logic                           clear;
    logic                           accept;
    logic                           s1_vld;
    logic                           s2_vld;
    logic                           s1_type;
    logic                           done_q;
    logic [CW-1:0]                  beat_cnt;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] s2_data;

    // Disabling behaves like a reset of the pass: in-flight beats are dropped.
    assign clear  = reset || !enable_activation;
    assign accept = enable_activation && bus.in_data_available;

    always_ff @(posedge clk) begin
        if (clear) begin
            s1_vld   <= 1'b0;
            s2_vld   <= 1'b0;
            s1_type  <= 1'b0;
            beat_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            s1_vld <= bus.in_data_available;
            s2_vld <= s1_vld;
            if (accept) begin
                s1_type <= activation_type;
            end
            if (accept && beat_cnt != BEATS) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            // Looks at next-cycle pipeline occupancy so done lands right after the last output pulse.
            if (beat_cnt == BEATS && !s1_vld && !bus.in_data_available) begin
                done_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < MAT_MUL_SIZE; i++) begin : g_lane
        logic signed [IW-1:0] x_ext;
        logic [IW-1:0]        mag_full;
        logic [DWIDTH-2:0]    mag_d;
        logic [1:0]           seg_d;
        logic [DWIDTH-2:0]    s1_mag;
        logic [1:0]           s1_seg;
        logic                 s1_sign;
        logic                 s1_mask;
        logic [IW-1:0]        a;
        logic [IW-1:0]        tanh_mag;
        logic signed [IW-1:0] res_full;
        logic [DWIDTH-1:0]    res;
        logic [DWIDTH-1:0]    s2_res;

        assign x_ext    = IW'($signed(bus.inp_data[i*DWIDTH +: DWIDTH]));
        assign mag_full = x_ext[IW-1] ? -x_ext : x_ext;
        // Only the most negative code exceeds the positive range; clamp it.
        assign mag_d    = (mag_full > MAG_MAX) ? MAG_MAX[DWIDTH-2:0] : (DWIDTH-1)'(mag_full);
        assign seg_d    = (mag_full < IW'(16)) ? 2'd0 :
                          (mag_full < IW'(32)) ? 2'd1 : 2'd2;

        always_ff @(posedge clk) begin
            if (clear) begin
                s1_mag  <= '0;
                s1_seg  <= '0;
                s1_sign <= 1'b0;
                s1_mask <= 1'b0;
            end else if (accept) begin
                s1_mag  <= mag_d;
                s1_seg  <= seg_d;
                s1_sign <= x_ext[IW-1];
                s1_mask <= bus.validity_mask[i];
            end
        end

        assign a = IW'(s1_mag);

        always_comb begin
            tanh_mag = IW'(16);
            case (s1_seg)
                2'd0:    tanh_mag = (a + (a << 1)) >> 2;
                2'd1:    tanh_mag = (a >> 2) + IW'(8);
                default: tanh_mag = IW'(16);
            endcase
        end

        always_comb begin
            res_full = '0;
            if (s1_type) begin
                res_full = s1_sign ? -$signed(tanh_mag) : $signed(tanh_mag);
            end else begin
                res_full = s1_sign ? '0 : $signed(a);
            end
        end

        assign res = s1_mask ? DWIDTH'(res_full) : '0;

        always_ff @(posedge clk) begin
            if (clear) begin
                s2_res <= '0;
            end else if (s1_vld) begin
                s2_res <= res;
            end
        end

        assign s2_data[i*DWIDTH +: DWIDTH] = s2_res;
    end

    assign bus.out_data           = enable_activation ? s2_data : bus.inp_data;
    assign bus.out_data_available = enable_activation ? s2_vld : bus.in_data_available;
    assign done_activation        = enable_activation ? done_q : 1'b1;
endmodule

// File: doc/activation_stage.md
ACTIVATION_STAGE -- requirements
Module: activation_stage

Interface
- REQ-001: Parameter MAT_MUL_SIZE, default 8, number of lanes per beat.
- REQ-002: Parameter DWIDTH, default 8, bits per lane, signed two's complement, Q4.4 format.
- REQ-003: Parameter MASK_WIDTH, default MAT_MUL_SIZE, one validity bit per lane.
- REQ-004: clk  input  1  clock; all state updates on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: enable_activation  input  1  1 = activation applied; 0 = bypass.
- REQ-007: activation_type  input  1  0 = ReLU, 1 = piecewise-linear tanh; sampled per beat at stage 1.
- REQ-008: in_data_available  input  1  inp_data holds a valid beat this cycle (pool stage output).
- REQ-009: inp_data  input  MAT_MUL_SIZE*DWIDTH  lane i at bits [i*DWIDTH +: DWIDTH].
- REQ-010: validity_mask  input  MASK_WIDTH  bit i = 1 means lane i is valid; sampled with the beat.
- REQ-011: out_data  output  MAT_MUL_SIZE*DWIDTH  activated beat, same lane packing.
- REQ-012: out_data_available  output  1  out_data holds a valid beat this cycle.
- REQ-013: done_activation  output  1  all MAT_MUL_SIZE beats of the current pass have been emitted.

Function
- REQ-014: When enabled, the stage SHALL be a 2-stage pipeline with one beat accepted per cycle, no backpressure, and fixed latency of 2 cycles from in_data_available to out_data_available.
- REQ-015: Stage 1 SHALL register, per lane: sign, |x| saturated to 127 (so -128 maps to 127), segment code, type, and mask bit; a valid bit SHALL track in_data_available.
- REQ-016: Stage 2 SHALL register the per-lane result and the valid bit; out_data and out_data_available SHALL be driven from stage 2 when enabled.
- REQ-017: ReLU: x < 0 -> 0; otherwise x unchanged.
- REQ-018: tanh segments on a=|x|: a < 16 -> (3*a)>>2; 16 <= a < 32 -> (a>>2)+8; a >= 32 -> 16. Result SHALL be negated when x < 0.
- REQ-019: Intermediate arithmetic SHALL be at least DWIDTH+2 bits wide; the final result always fits in DWIDTH bits with no overflow.
- REQ-020: A lane whose mask bit is 0 SHALL output 0 regardless of its data.
- REQ-021: Gaps in in_data_available SHALL NOT flush the pipeline; beats already in flight SHALL emerge at their scheduled cycle.
- REQ-022: A beat counter SHALL increment on each accepted beat and saturate at MAT_MUL_SIZE; beats beyond it are still processed.
- REQ-023: done_activation SHALL rise the cycle after the counter equals MAT_MUL_SIZE and both pipeline valid bits are 0, then stay high (sticky).
- REQ-024: Bypass (enable_activation = 0): out_data = inp_data and out_data_available = in_data_available combinationally, done_activation = 1; pipeline valids, counter and done register SHALL be cleared.
- REQ-025: Disabling mid-pass SHALL discard in-flight beats; re-enabling SHALL start a new pass with the counter at 0.

Reset
- REQ-026: While reset is high at a clock edge: pipeline data and valid bits = 0, counter = 0, done register = 0.
- REQ-027: Immediately after reset with enable high, out_data = 0, out_data_available = 0, done_activation = 0.
- REQ-028: Reset mid-pass SHALL drop all in-flight beats; no out_data_available pulse from pre-reset beats SHALL appear afterward.

Verification
- REQ-029: ReLU, all masks 1, lanes {-128,-1,0,1,5,64,127,-50} -> 2 cycles later {0,0,0,1,5,64,127,0}, out_data_available high for exactly 1 cycle.
- REQ-030: tanh, lanes {4,-4,16,-20,31,32,-128,127} -> {3,-3,12,-13,15,16,-16,16}.
- REQ-031: validity_mask = 8'b00001111 with all lanes 50 under ReLU -> lanes 0-3 = 50, lanes 4-7 = 0.
- REQ-032: 8 beats with a 2-cycle gap after beat 3 -> 8 output pulses with the same gap; done_activation rises 1 cycle after the last pulse and stays high.
- REQ-033: Reset asserted 1 cycle after beat 5 is accepted -> no further out_data_available; done_activation = 0; a fresh 8-beat pass then completes normally.
- REQ-034: enable_activation = 0, inp_data = 0x0123456789ABCDEF, in_data_available = 1 -> out_data = same value in the same cycle, out_data_available = 1, done_activation = 1.
